if_stage: RTL and testbench

- Instruction-fetch stage directly downstream of the PC register.
- Takes the current fetch PC, looks it up in a small direct-mapped instruction cache, and on a miss fetches a 32-bit word from the memory controller.
- Presents {pc, instruction} to the IF/ID latch and raises a stall request so the PC register holds while a miss is outstanding.
- Squashes in-flight fetches on a branch/jump redirect from EX.

---
 rtl/if_stage.sv | 154 +++++++++++++++
 tb/tb_if_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: direct-mapped I-cache lookup on the fetch PC, a single
// outstanding refill to the memory controller, and wrong-path squash on EX redirects.
module if_stage #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TAG_BITS   = 24
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] pc,
  input  logic        jump_enable,
  input  logic [5:0]  stall_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  output logic        stall_req,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic                  squash_q, squash_d;
  logic                  mem_req_d;
  logic [31:0]           mem_addr_d;
  logic [31:0]           if_pc_d, if_inst_d;
  logic                  if_valid_d;
  logic                  fill_we;

  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_ram  [LINES];
  logic [31:0]           data_ram [LINES];

  logic [INDEX_BITS-1:0] lk_idx, fill_idx;
  logic [TAG_BITS-1:0]   lk_tag, fill_tag;
  logic                  hit;
  logic                  hold;
  logic                  unused_bits;

  assign lk_idx   = pc[INDEX_BITS+1:2];
  assign lk_tag   = pc[31:INDEX_BITS+2];
  assign fill_idx = mem_addr[INDEX_BITS+1:2];
  assign fill_tag = mem_addr[31:INDEX_BITS+2];
  assign hold     = stall_in[1];

  assign unused_bits = ^{pc[1:0], stall_in[5:2], stall_in[0]};

  assign hit = valid_q[lk_idx] && (tag_ram[lk_idx] == lk_tag);

  // Held low while in reset so the stall controller sees a quiet IF stage.
  assign stall_req = rst_in &&
                     (((state_q == S_IDLE) && !hit && !jump_enable) || (state_q == S_WAIT));

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    squash_d   = squash_q;
    mem_req_d  = mem_req;
    mem_addr_d = mem_addr;
    if_pc_d    = if_pc;
    if_inst_d  = if_inst;
    if_valid_d = if_valid;
    fill_we    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (jump_enable) begin
          if_valid_d = 1'b0;
        end else if (hit) begin
          if (!hold) begin
            if_pc_d    = pc;
            if_inst_d  = data_ram[lk_idx];
            if_valid_d = 1'b1;
          end
        end else begin
          state_d    = S_WAIT;
          mem_req_d  = 1'b1;
          mem_addr_d = pc;
          squash_d   = 1'b0;
          if (!hold) begin
            if_valid_d = 1'b0;
          end
        end
      end

      S_WAIT: begin
        if (mem_done) begin
          // The line is filled even for a squashed fetch; it is still a correct word.
          fill_we   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
          if (!squash_q && !jump_enable && !hold) begin
            if_pc_d    = mem_addr;
            if_inst_d  = mem_data;
            if_valid_d = 1'b1;
          end else begin
            if_valid_d = 1'b0;
          end
        end else if (jump_enable) begin
          squash_d   = 1'b1;
          if_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers; rdy_in gates everything except reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q  <= S_IDLE;
      squash_q <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0;
      if_pc    <= 32'h0;
      if_inst  <= NOP;
      if_valid <= 1'b0;
      valid_q  <= '0;
    end else if (rdy_in) begin
      state_q  <= state_d;
      squash_q <= squash_d;
      mem_req  <= mem_req_d;
      mem_addr <= mem_addr_d;
      if_pc    <= if_pc_d;
      if_inst  <= if_inst_d;
      if_valid <= if_valid_d;
      if (fill_we) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in && fill_we) begin
      tag_ram[fill_idx]  <= fill_tag;
      data_ram[fill_idx] <= mem_data;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a line-address cache model checked every cycle,
// plus hand-computed literal checks along the test plan.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] pc;
  logic        jump_enable;
  logic [5:0]  stall_in;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;
  logic        stall_req;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  always #5 clk_in = ~clk_in;

  if_stage dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .pc          (pc),
    .jump_enable (jump_enable),
    .stall_in    (stall_in),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_done    (mem_done),
    .mem_data    (mem_data),
    .stall_req   (stall_req),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .if_valid    (if_valid)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Model: each line remembers the full word address it holds; one pending fetch.
  bit          m_valid [64];
  logic [31:0] m_laddr [64];
  logic [31:0] m_ldata [64];
  bit          m_pending = 1'b0;
  bit          m_wrong_path = 1'b0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] e_pc = 32'h0;
  logic [31:0] e_inst = NOP;
  bit          e_valid = 1'b0;

  function automatic bit cached(input logic [31:0] a);
    return m_valid[a[7:2]] && (m_laddr[a[7:2]] == a);
  endfunction

  always @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 64; i++) m_valid[i] <= 1'b0;
      m_pending    <= 1'b0;
      m_wrong_path <= 1'b0;
      m_addr       <= 32'h0;
      e_pc         <= 32'h0;
      e_inst       <= NOP;
      e_valid      <= 1'b0;
    end else if (rdy_in) begin
      if (m_pending) begin
        if (mem_done) begin
          m_valid[m_addr[7:2]] <= 1'b1;
          m_laddr[m_addr[7:2]] <= m_addr;
          m_ldata[m_addr[7:2]] <= mem_data;
          m_pending            <= 1'b0;
          if (m_wrong_path || jump_enable || stall_in[1]) e_valid <= 1'b0;
          else begin
            e_pc    <= m_addr;
            e_inst  <= mem_data;
            e_valid <= 1'b1;
          end
        end else if (jump_enable) begin
          m_wrong_path <= 1'b1;
          e_valid      <= 1'b0;
        end
      end else if (jump_enable) begin
        e_valid <= 1'b0;
      end else if (cached(pc)) begin
        if (!stall_in[1]) begin
          e_pc    <= pc;
          e_inst  <= m_ldata[pc[7:2]];
          e_valid <= 1'b1;
        end
      end else begin
        m_pending    <= 1'b1;
        m_addr       <= pc;
        m_wrong_path <= 1'b0;
        if (!stall_in[1]) e_valid <= 1'b0;
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk_in) begin
    if (chk_en) begin
      check("stall_req", 32'(stall_req),
            32'(rst_in && (m_pending || (!jump_enable && !cached(pc)))));
      check("mem_req", 32'(mem_req), 32'(m_pending));
      if (m_pending) check("mem_addr", mem_addr, m_addr);
      check("if_valid", 32'(if_valid), 32'(e_valid));
      if (e_valid) begin
        check("if_pc", if_pc, e_pc);
        check("if_inst", if_inst, e_inst);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  // Memory answers on the third edge after the request is seen.
  task automatic mem_resp(input logic [31:0] data);
    tick();
    tick();
    mem_done = 1'b1;
    mem_data = data;
    tick();
    mem_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; pc = 32'h0; jump_enable = 1'b0;
    stall_in = 6'h0; mem_done = 1'b0; mem_data = 32'h0;

    // Reset state
    tick();
    chk_en = 1'b1;
    tick();
    check("lit_rst_mem_req", 32'(mem_req), 32'h0);
    check("lit_rst_mem_addr", mem_addr, 32'h0);
    check("lit_rst_if_pc", if_pc, 32'h0);
    check("lit_rst_if_inst", if_inst, NOP);
    check("lit_rst_if_valid", 32'(if_valid), 32'h0);
    check("lit_rst_stall", 32'(stall_req), 32'h0);

    // Cold miss on 0
    rst_in = 1'b1; pc = 32'h0;
    #1 check("lit_cold_stall", 32'(stall_req), 32'h1);
    tick();
    check("lit_cold_req", 32'(mem_req), 32'h1);
    check("lit_cold_addr", mem_addr, 32'h0);
    mem_resp(32'h0050_0093);
    check("lit_cold_pc", if_pc, 32'h0);
    check("lit_cold_inst", if_inst, 32'h0050_0093);
    check("lit_cold_valid", 32'(if_valid), 32'h1);

    // Hit after fill
    #1 check("lit_hit_stall", 32'(stall_req), 32'h0);
    tick();
    check("lit_hit_inst", if_inst, 32'h0050_0093);
    check("lit_hit_req", 32'(mem_req), 32'h0);

    // Conflict eviction in index 0
    pc = 32'h100;
    tick();
    check("lit_conf_addr100", mem_addr, 32'h100);
    mem_resp(32'h1111_1111);
    pc = 32'h0;
    #1 check("lit_conf_stall0", 32'(stall_req), 32'h1);
    tick();
    check("lit_conf_req0", 32'(mem_req), 32'h1);
    check("lit_conf_addr0", mem_addr, 32'h0);
    mem_resp(32'h0050_0093);
    pc = 32'h100;
    #1 check("lit_conf_stall100", 32'(stall_req), 32'h1);
    tick();
    mem_resp(32'h1111_1111);

    // Jump one cycle before mem_done
    pc = 32'h40;
    tick();
    tick();
    jump_enable = 1'b1;
    tick();
    jump_enable = 1'b0;
    mem_done = 1'b1; mem_data = 32'h2222_2222;
    tick();
    mem_done = 1'b0;
    check("lit_jmp_valid", 32'(if_valid), 32'h0);
    #1 check("lit_jmp_rehit_stall", 32'(stall_req), 32'h0);
    tick();
    check("lit_jmp_rehit_pc", if_pc, 32'h40);
    check("lit_jmp_rehit_inst", if_inst, 32'h2222_2222);
    check("lit_jmp_rehit_req", 32'(mem_req), 32'h0);

    // Downstream stall holds the output registers
    pc = 32'h4;
    tick();
    mem_resp(32'h3333_3333);
    tick();
    stall_in = 6'b000010;
    pc = 32'h100; tick();
    check("lit_stl1_pc", if_pc, 32'h4);
    check("lit_stl1_inst", if_inst, 32'h3333_3333);
    pc = 32'h40; tick();
    check("lit_stl2_pc", if_pc, 32'h4);
    pc = 32'h100; tick();
    check("lit_stl3_pc", if_pc, 32'h4);
    check("lit_stl3_inst", if_inst, 32'h3333_3333);
    stall_in = 6'h0;

    // rdy_in low during WAIT, with a mem_done pulse inside the window
    pc = 32'h200;
    tick();
    rdy_in = 1'b0;
    tick();
    mem_done = 1'b1; mem_data = 32'h4444_4444;
    tick();
    mem_done = 1'b0;
    tick();
    tick();
    check("lit_rdy_req", 32'(mem_req), 32'h1);
    check("lit_rdy_addr", mem_addr, 32'h200);
    rdy_in = 1'b1;
    tick();
    check("lit_rdy_still_wait", 32'(mem_req), 32'h1);
    mem_done = 1'b1; mem_data = 32'h5555_5555;
    tick();
    mem_done = 1'b0;
    check("lit_rdy_inst", if_inst, 32'h5555_5555);
    check("lit_rdy_pc", if_pc, 32'h200);
    pc = 32'h100;
    #1 check("lit_rdy_evicted", 32'(stall_req), 32'h1);

    // Jump in IDLE: bubble, no request
    pc = 32'h40; jump_enable = 1'b1;
    #1 check("lit_jidle_stall", 32'(stall_req), 32'h0);
    tick();
    check("lit_jidle_valid", 32'(if_valid), 32'h0);
    pc = 32'h300;
    tick();
    check("lit_jidle_noreq", 32'(mem_req), 32'h0);
    jump_enable = 1'b0;

    // Reset mid-miss
    tick();
    rst_in = 1'b0;
    tick();
    check("lit_rstmiss_req", 32'(mem_req), 32'h0);
    rst_in = 1'b1; pc = 32'h4;
    #1 check("lit_rstmiss_stall", 32'(stall_req), 32'h1);
    tick();
    mem_resp(32'h6666_6666);
    check("lit_rstmiss_inst", if_inst, 32'h6666_6666);
    tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
